// File: rtl/simplerisc_pkg.sv
// Shared definitions for the simplerisc fetch front end.
package simplerisc_pkg;

    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned OPCODE_MSB = 31;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {instr, pc} while decode is stalled.
module fetch_skid_buf #(
    parameter int unsigned W = 39
) (
    input  logic         clka,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    // Load captures a word and wins over clear; clear only drops the valid flag.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/im_fetch_controller.sv
// Fetch sequencer for a 1-cycle synchronous instruction memory: owns the PC,
// tracks the single read in flight, absorbs decode stalls and handles redirect/halt.
module im_fetch_controller #(
    parameter int unsigned                         N           = 7,
    parameter logic [N-1:0]                        RESET_PC    = '0,
    parameter logic [simplerisc_pkg::OPCODE_W-1:0] HALT_OPCODE = simplerisc_pkg::HALT_OPCODE
) (
    input  logic         clka,
    input  logic         reset,
    input  logic         start_i,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic [N-1:0] im_addr_o,
    input  logic [31:0]  im_data_i,
    output logic [31:0]  instr_o,
    output logic [N-1:0] instr_pc_o,
    output logic         instr_valid_o,
    output logic         halted_o
);

    import simplerisc_pkg::*;

    localparam int unsigned SKID_W = 32 + N;

    fetch_state_e state;
    logic [N-1:0] pc;
    logic [N-1:0] inflight_pc;
    logic         inflight;

    logic              skid_valid;
    logic [SKID_W-1:0] skid_q;
    logic              skid_load_c;
    logic              skid_clear_c;

    logic issue_c;
    logic accept_c;
    logic halt_take_c;

    // Address, issue decision, output mux and stall/halt qualifiers.
    always_comb begin
        im_addr_o     = redirect_i ? redirect_pc_i : pc;
        issue_c       = ((state == ST_RUN) && !stall_i)
                      || ((state == ST_IDLE) && start_i)
                      || ((state != ST_IDLE) && redirect_i);
        instr_o       = skid_valid ? skid_q[SKID_W-1:N] : im_data_i;
        instr_pc_o    = skid_valid ? skid_q[N-1:0]      : inflight_pc;
        instr_valid_o = (skid_valid || inflight) && !redirect_i && (state != ST_HALT);
        halted_o      = (state == ST_HALT);
        accept_c      = instr_valid_o && !stall_i;
        halt_take_c   = accept_c && (instr_o[OPCODE_MSB -: OPCODE_W] == HALT_OPCODE);
        skid_load_c   = stall_i && inflight && !redirect_i;
        skid_clear_c  = redirect_i || !stall_i;
    end

    // FSM, PC and in-flight read tracking; a halt squashes the younger read.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: if (start_i)     state <= ST_RUN;
                ST_RUN:  if (halt_take_c) state <= ST_HALT;
                ST_HALT: if (redirect_i)  state <= ST_RUN;
                default:                  state <= ST_IDLE;
            endcase
            if (issue_c) begin
                pc          <= im_addr_o + N'(1);
                inflight_pc <= im_addr_o;
            end
            inflight <= issue_c && !halt_take_c;
        end
    end

    fetch_skid_buf #(
        .W(SKID_W)
    ) u_skid (
        .clka  (clka),
        .reset (reset),
        .load  (skid_load_c),
        .clear (skid_clear_c),
        .din   ({im_data_i, inflight_pc}),
        .dout  (skid_q),
        .valid (skid_valid)
    );

endmodule

// File: tb/tb_im_fetch_controller.sv
// Testbench for im_fetch_controller: directed scenarios plus a randomized phase,
// all checked against a pending-word reference model driven by the memory image.
module tb_im_fetch_controller;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic        clka = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [6:0]  redirect_pc_i = '0;
    logic [6:0]  im_addr_o;
    logic [31:0] im_q;
    logic [31:0] instr_o;
    logic [6:0]  instr_pc_o;
    logic        instr_valid_o;
    logic        halted_o;

    logic [6:0]  im_addr2;
    logic [31:0] im_q2;
    logic [31:0] instr2;
    logic [6:0]  pc2;
    logic        valid2;
    logic        halted2;

    logic [31:0] mem [128];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: one pending word (either in flight or held) plus fetch state
    int         m_state;
    logic [6:0] m_pc;
    bit         m_has;
    logic [6:0] m_ppc;
    logic [6:0] e_addr;
    bit         e_valid;

    always #5 clka = ~clka;

    // synchronous instruction memories, one per DUT
    always @(posedge clka) begin
        im_q  <= mem[im_addr_o];
        im_q2 <= mem[im_addr2];
    end

    im_fetch_controller #(.N(7), .RESET_PC(7'd0), .HALT_OPCODE(5'b11111)) dut (
        .clka          (clka),
        .reset         (reset),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .im_addr_o     (im_addr_o),
        .im_data_i     (im_q),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .halted_o      (halted_o)
    );

    im_fetch_controller #(.N(7), .RESET_PC(7'd127), .HALT_OPCODE(5'b11111)) dut2 (
        .clka          (clka),
        .reset         (reset),
        .start_i       (start_i),
        .stall_i       (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (7'd0),
        .im_addr_o     (im_addr2),
        .im_data_i     (im_q2),
        .instr_o       (instr2),
        .instr_pc_o    (pc2),
        .instr_valid_o (valid2),
        .halted_o      (halted2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_pc    = 7'd0;
        m_has   = 1'b0;
        m_ppc   = 7'd0;
    endtask

    // apply inputs after the falling edge and compare every output with the model
    task automatic drive(input bit s, input bit st, input bit rd, input logic [6:0] rp);
        @(negedge clka);
        start_i       = s;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rp;
        #1;
        e_addr  = rd ? rp : m_pc;
        e_valid = m_has && !rd && (m_state != S_HALT);
        chk("im_addr", 32'(im_addr_o), 32'(e_addr));
        chk("instr_valid", 32'(instr_valid_o), 32'(e_valid));
        chk("halted", 32'(halted_o), 32'(m_state == S_HALT));
        if (e_valid) begin
            chk("instr_pc", 32'(instr_pc_o), 32'(m_ppc));
            chk("instr", instr_o, mem[m_ppc]);
        end
        chk("skid_and_inflight", 32'(dut.inflight && dut.skid_valid), 32'd0);
    endtask

    // advance the model across the rising edge
    task automatic tick();
        bit          acc;
        bit          hlt;
        bit          iss;
        logic [31:0] w;
        w   = mem[m_ppc];
        acc = e_valid && !stall_i;
        hlt = acc && (w[31:27] == 5'b11111);
        iss = ((m_state == S_RUN) && !stall_i) || ((m_state == S_IDLE) && start_i)
           || ((m_state != S_IDLE) && redirect_i);
        @(posedge clka);
        m_has = (iss && !hlt) ? 1'b1 : (m_has && stall_i && !redirect_i);
        if (iss) begin
            m_pc = e_addr + 7'd1;
            if (!hlt) m_ppc = e_addr;
        end
        if (m_state == S_IDLE && start_i) m_state = S_RUN;
        else if (m_state == S_RUN && hlt) m_state = S_HALT;
        else if (m_state == S_HALT && redirect_i) m_state = S_RUN;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h100 + 32'(i);
        mem[9] = {5'b11111, 27'h9};
        model_reset();

        // reset values
        repeat (2) @(negedge clka);
        #1;
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_addr", 32'(im_addr_o), 32'd0);
        chk("rst_addr2", 32'(im_addr2), 32'd127);
        reset = 1'b0;

        // stall-free stream from pc 0, and the wrapping instance from pc 127
        drive(1, 0, 0, 0);
        chk("t1_start_addr", 32'(im_addr_o), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0);
            chk("t1_pc", 32'(instr_pc_o), 32'(k));
            chk("t1_instr", instr_o, 32'h100 + 32'(k));
            if (k < 3) begin
                chk("t5_valid", 32'(valid2), 32'd1);
                chk("t5_pc", 32'(pc2), 32'((127 + k) % 128));
                chk("t5_instr", instr2, mem[(127 + k) % 128]);
                chk("t5_halted", 32'(halted2), 32'd0);
            end
            tick();
        end

        // three-cycle stall while pc 5 is presented
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            chk("t2_hold_pc", 32'(instr_pc_o), 32'd5);
            chk("t2_hold_instr", instr_o, 32'h105);
            tick();
        end
        for (int k = 5; k < 8; k++) begin
            drive(0, 0, 0, 0);
            chk("t2_after_pc", 32'(instr_pc_o), 32'(k));
            tick();
        end

        // redirect while the skid holds a word
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 1, 7'h40);
        chk("t3_squash", 32'(instr_valid_o), 32'd0);
        tick();
        drive(0, 0, 0, 0);
        chk("t3_target_pc", 32'(instr_pc_o), 32'h40);
        tick();
        drive(0, 0, 0, 0); tick();

        // halt word at pc 9, then leave HALT by redirecting to 0
        drive(0, 0, 1, 7'd8); tick();
        drive(0, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("t4_halt_pc", 32'(instr_pc_o), 32'd9);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0);
            chk("t4_halted", 32'(halted_o), 32'd1);
            chk("t4_no_valid", 32'(instr_valid_o), 32'd0);
            tick();
        end
        drive(0, 0, 1, 7'd0); tick();
        drive(0, 0, 0, 0);
        chk("t4_resume_halted", 32'(halted_o), 32'd0);
        chk("t4_resume_pc", 32'(instr_pc_o), 32'd0);
        tick();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 10), 7'($urandom_range(0, 127)));
            tick();
        end

        // asynchronous reset with the skid full
        drive(0, 0, 1, 7'h20); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 0, 0);
        chk("t6_pre_pc", 32'(instr_pc_o), 32'h20);
        reset = 1'b1;
        #1;
        chk("t6_valid", 32'(instr_valid_o), 32'd0);
        chk("t6_halted", 32'(halted_o), 32'd0);
        chk("t6_addr", 32'(im_addr_o), 32'd0);
        model_reset();
        @(posedge clka);
        @(negedge clka);
        start_i = 1'b0;
        stall_i = 1'b0;
        reset   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, ($urandom_range(0, 1) == 1), 0, 0);
            tick();
        end
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("t6_restart_pc", 32'(instr_pc_o), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
